// File: rtl/dijkstra_multilane_if.sv
// Host control, edge-cache request and path-stream signals of the Dijkstra engine.
// master = engine side; slave = host / edge cache / path sink side.
interface dijkstra_multilane_if #(
  parameter int INDEX_WIDTH = 6,
  parameter int VALUE_WIDTH = 16,
  parameter int LANES       = 4
);
  logic                         start;
  logic [INDEX_WIDTH-1:0]       source;
  logic [INDEX_WIDTH-1:0]       destination;
  logic [INDEX_WIDTH:0]         number_of_nodes;
  logic                         busy;
  logic                         done;
  logic                         no_path;
  logic [VALUE_WIDTH-1:0]       shortest_distance;

  logic                         ec_query;
  logic [INDEX_WIDTH-1:0]       ec_from_node;
  logic [INDEX_WIDTH-1:0]       ec_to_node_base;
  logic                         ec_ready;
  logic [LANES*VALUE_WIDTH-1:0] ec_edge_values;

  logic                         path_valid;
  logic [INDEX_WIDTH-1:0]       path_node;
  logic                         path_last;
  logic                         path_ready;

  modport master (
    input  start, source, destination, number_of_nodes, ec_ready, ec_edge_values, path_ready,
    output busy, done, no_path, shortest_distance, ec_query, ec_from_node, ec_to_node_base,
           path_valid, path_node, path_last
  );

  modport slave (
    output start, source, destination, number_of_nodes, ec_ready, ec_edge_values, path_ready,
    input  busy, done, no_path, shortest_distance, ec_query, ec_from_node, ec_to_node_base,
           path_valid, path_node, path_last
  );
endinterface

// File: rtl/dijkstra_multilane.sv
// Dijkstra engine with LANES-wide edge relaxation and internal dist/visited/prev store.
// Per visited node: 1 select cycle + (fetch + relax) per lane group; ec and path ports stall on ready.
module dijkstra_multilane #(
  parameter int MAX_NODES   = 64,
  parameter int INDEX_WIDTH = 6,
  parameter int VALUE_WIDTH = 16,
  parameter int LANES       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  dijkstra_multilane_if.master bus
);
  localparam int IW = INDEX_WIDTH;
  localparam int VW = VALUE_WIDTH;
  localparam int BW = INDEX_WIDTH + 2;
  localparam logic [VW-1:0] INF   = '1;
  localparam logic [IW:0]   N_MAX = (IW+1)'(MAX_NODES);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SELECT, S_FETCH, S_RELAX, S_PATH, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       src_q, dst_q, cur_q, path_q;
  logic [IW:0]         n_q;
  logic [BW-1:0]       base_q;
  logic [LANES*VW-1:0] edge_q;
  logic                no_path_q;
  logic [VW-1:0]       sd_q;

  logic [VW-1:0]        dist_q [MAX_NODES];
  logic [IW-1:0]        prev_q [MAX_NODES];
  logic [MAX_NODES-1:0] visited_q;

  logic          illegal;
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [VW-1:0] sel_val;
  logic [BW-1:0] base_nxt;
  logic [BW-1:0] lane_t   [LANES];
  logic [IW-1:0] lane_idx [LANES];
  logic [VW:0]   lane_sum [LANES];
  logic [LANES-1:0] lane_upd;

  assign illegal  = (n_q == '0) || (n_q > N_MAX) ||
                    ({1'b0, src_q} >= n_q) || ({1'b0, dst_q} >= n_q);
  assign base_nxt = base_q + BW'(LANES);

  // Strict less-than while scanning upward keeps ties on the lowest index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_val   = INF;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (({1'b0, IW'(i)} < n_q) && !visited_q[i] && (dist_q[i] < sel_val)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_val   = dist_q[i];
      end
    end
  end

  // Sum carries one extra bit so a saturating path is rejected instead of wrapping.
  always_comb begin
    lane_t   = '{default: '0};
    lane_idx = '{default: '0};
    lane_sum = '{default: '0};
    lane_upd = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_t[k]   = base_q + BW'(k);
      lane_idx[k] = lane_t[k][IW-1:0];
      lane_sum[k] = {1'b0, dist_q[cur_q]} + {1'b0, edge_q[k*VW +: VW]};
      lane_upd[k] = (lane_t[k] < BW'(n_q)) && !visited_q[lane_idx[k]] &&
                    (edge_q[k*VW +: VW] != INF) && (lane_sum[k] < {1'b0, INF}) &&
                    (lane_sum[k][VW-1:0] < dist_q[lane_idx[k]]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.ec_query   = 1'b0;
    bus.path_valid = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_INIT;
      S_INIT: begin
        bus.busy = 1'b1;
        state_d  = illegal ? S_DONE : S_SELECT;
      end
      S_SELECT: begin
        bus.busy = 1'b1;
        if (!sel_found)            state_d = S_DONE;
        else if (sel_idx == dst_q) state_d = S_PATH;
        else                       state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.busy     = 1'b1;
        bus.ec_query = 1'b1;
        if (bus.ec_ready) state_d = S_RELAX;
      end
      S_RELAX: begin
        bus.busy = 1'b1;
        state_d  = (base_nxt >= BW'(n_q)) ? S_SELECT : S_FETCH;
      end
      S_PATH: begin
        bus.busy       = 1'b1;
        bus.path_valid = 1'b1;
        if (bus.path_ready && (path_q == src_q)) state_d = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (bus.start) state_d = S_INIT;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.ec_from_node      = cur_q;
  assign bus.ec_to_node_base   = base_q[IW-1:0];
  assign bus.path_node         = path_q;
  assign bus.path_last         = (state_q == S_PATH) && (path_q == src_q);
  assign bus.no_path           = no_path_q;
  assign bus.shortest_distance = sd_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q     <= '0;
      dst_q     <= '0;
      n_q       <= '0;
      cur_q     <= '0;
      base_q    <= '0;
      path_q    <= '0;
      edge_q    <= '0;
      no_path_q <= 1'b0;
      sd_q      <= INF;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            src_q     <= bus.source;
            dst_q     <= bus.destination;
            n_q       <= bus.number_of_nodes;
            no_path_q <= 1'b0;
            sd_q      <= INF;
          end
        end
        S_INIT:   if (illegal) no_path_q <= 1'b1;
        S_SELECT: begin
          if (!sel_found)            no_path_q <= 1'b1;
          else if (sel_idx == dst_q) path_q    <= dst_q;
          else begin
            cur_q  <= sel_idx;
            base_q <= '0;
          end
        end
        S_FETCH:  if (bus.ec_ready) edge_q <= bus.ec_edge_values;
        S_RELAX:  base_q <= base_nxt;
        S_PATH: begin
          if (bus.path_ready) begin
            if (path_q == src_q) sd_q   <= dist_q[dst_q];
            else                 path_q <= prev_q[path_q];
          end
        end
        default: ;
      endcase
    end
  end

  // Node store is fully rewritten in INIT, so it needs no reset.
  always_ff @(posedge clock) begin
    case (state_q)
      S_INIT: begin
        for (int i = 0; i < MAX_NODES; i++) begin
          dist_q[i] <= INF;
          prev_q[i] <= IW'(i);
        end
        visited_q     <= '0;
        dist_q[src_q] <= '0;
      end
      S_SELECT: if (sel_found) visited_q[sel_idx] <= 1'b1;
      S_RELAX: begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_upd[k]) begin
            dist_q[lane_idx[k]] <= lane_sum[k][VW-1:0];
            prev_q[lane_idx[k]] <= cur_q;
          end
        end
      end
      default: ;
    endcase
  end
endmodule

// File: doc/dijkstra_multilane.md
Name: dijkstra_multilane

Overview:
Next-generation hardware Dijkstra engine. It adds configurable parallel edge relaxation (LANES edges fetched and relaxed per edge-cache transaction) and an internal distance/visited/predecessor store with single-cycle min selection. It also detects unreachable destinations and streams the shortest path out on a valid/ready port. It sits between the host control logic and the edge cache, and replaces the single-lane engine and its external priority queue.

Parameters:
MAX_NODES, 64, node capacity of internal arrays.
INDEX_WIDTH, 6, node index width; must satisfy 2^INDEX_WIDTH >= MAX_NODES.
VALUE_WIDTH, 16, distance/edge weight width; all-ones = INF (no edge / unreached).
LANES, 4, edges relaxed per edge-cache transaction; power of two, 1..MAX_NODES.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; latches source/destination/number_of_nodes when idle.
source  in  INDEX_WIDTH  start node.
destination  in  INDEX_WIDTH  target node.
number_of_nodes  in  INDEX_WIDTH+1  live node count, 0..MAX_NODES.
ec_query  out  1  edge-cache request, held until accepted.
ec_from_node  out  INDEX_WIDTH  row (current node).
ec_to_node_base  out  INDEX_WIDTH  first column of lane group; lane k addresses base+k.
ec_ready  in  1  request accepted; ec_edge_values valid this cycle.
ec_edge_values  in  LANES*VALUE_WIDTH  lane k in bits [k*VALUE_WIDTH +: VALUE_WIDTH].
busy  out  1  run in progress (start to DONE).
done  out  1  high in DONE until next start.
no_path  out  1  valid with done; destination unreachable or inputs illegal.
shortest_distance  out  VALUE_WIDTH  distance to destination, valid with done; INF when no_path.
path_valid  out  1  path stream data valid.
path_node  out  INDEX_WIDTH  path node, destination first, source last.
path_last  out  1  marks source node (final beat).
path_ready  in  1  stream sink ready.

Behaviour:
- Reset (reset low, async): state IDLE. busy, done, no_path, ec_query, path_valid, path_last = 0. ec_from_node, ec_to_node_base, path_node = 0. shortest_distance = INF. Reset mid-run aborts immediately; a transaction in flight is dropped.
- States: IDLE, INIT, SELECT, FETCH, RELAX, PATH, DONE.
- IDLE: start -> INIT, with busy=1 and done=0. start outside IDLE/DONE is ignored. start in DONE restarts.
- INIT (1 cycle): dist[all]=INF, visited=0, prev[all]=self. Then dist[source]=0.
  - If number_of_nodes==0, or source/destination >= number_of_nodes: DONE with no_path=1.
- SELECT (1 cycle): combinational min over unvisited nodes < number_of_nodes. Ties go to the lowest index. Let m be the selected node.
  - If min value is INF, or no unvisited node remains: DONE with no_path=1.
  - If m == destination: mark visited, go to PATH.
  - Otherwise: mark m visited, current=m, base=0, go to FETCH.
- FETCH: ec_query=1, ec_from_node=current, ec_to_node_base=base. Outputs are stable until the cycle where ec_query && ec_ready. Values are captured that cycle; ec_query drops next cycle; go to RELAX.
- RELAX (1 cycle), per lane k, with t = base+k:
  - Skip the lane if t >= number_of_nodes, t is visited, or edge == INF.
  - sum = dist[current] + edge, computed at VALUE_WIDTH+1 bits. If sum >= INF, skip.
  - If sum < dist[t]: dist[t]=sum, prev[t]=current. Lanes target distinct nodes, so there are no write conflicts.
  - Then base += LANES. If base >= number_of_nodes -> SELECT, else -> FETCH.
- PATH: walk prev from destination, presenting path_node with path_valid=1.
  - Advance only on path_valid && path_ready. Data is held stable while path_ready is low.
  - path_last=1 when path_node==source. The beat after that handshake goes to DONE.
- DONE: done=1, busy=0, path_valid=0.
  - shortest_distance = dist[destination]. no_path=1 iff it is INF.
  - No path stream is emitted when no_path=1.
- Minimum cost per visited node: 1 + ceil(number_of_nodes/LANES) * 2 cycles, assuming zero-wait ec_ready.

Test Plan:
- Basic, LANES=2, N=4. Edges 0->1=4, 0->2=1, 2->1=2, 1->3=5, 2->3=8, all others INF. start src=0 dst=3 -> done, no_path=0, shortest_distance=8. Path stream 3,1,2,0 with path_last only on 0.
- Unreachable: same graph, src=3 dst=0 -> done, no_path=1, shortest_distance=INF (0xFFFF), no path_valid pulses.
- source==destination=2 -> shortest_distance=0, single beat path_node=2 with path_last=1.
- Backpressure and wait states: ec_ready delayed 3 cycles per request, path_ready toggled 1/0. ec_query, addresses and path data must hold stable; results identical to the basic test.
- Saturation: edge 0->1=0xFFFE, 1->2=0x0005, N=3, dst=2 -> no_path=1, dist stays INF, no overflow wrap. Illegal inputs N=0 or src=5 with N=4 -> done with no_path=1 within 2 cycles of start.
- Reset mid-run: drive reset low while ec_query=1 -> all outputs at reset values immediately. A following start produces the correct basic-test result; a start pulse while busy is ignored.
